// File: rtl/multi_timer.sv
// Multi-channel bus timer: per-channel prescaler, up-counter, compare/match flag,
// auto-reload and IRQ enable. Define TIMER_CAPTURE_EN to build the input-capture logic.
module multi_timer #(
    parameter logic [15:0] BASE_ADDR = 16'h8200,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [15:0]       read_addr,
    output logic [15:0]       read_data,
    input  logic [15:0]       write_addr,
    input  logic [15:0]       write_data,
    input  logic              write_strobe,
    input  logic [NUM_CH-1:0] i_capture,
    output logic              o_irq
);
    localparam logic [15:0] PEND_OFF = 16'(NUM_CH * 8);
    localparam bit          WIDE     = (CNT_WIDTH == 32);

    logic [15:0]       rd_rel;
    logic [15:0]       wr_rel;
    logic              wr_any;
    logic [15:0]       reg_x [NUM_CH][8];
    logic [NUM_CH-1:0] flag_v;
    logic [NUM_CH-1:0] cap_flag_v;
    logic [NUM_CH-1:0] irq_en_v;
    logic [15:0]       rd_next;

    // Offsets relative to the block; anything at or above PEND_OFF is not a channel word.
    assign rd_rel = read_addr - BASE_ADDR;
    assign wr_rel = write_addr - BASE_ADDR;
    assign wr_any = write_strobe && (wr_rel < PEND_OFF);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                 en;
        logic                 auto_reload;
        logic                 irq_en;
        logic                 flag;
        logic                 cap_flag;
        logic [CNT_WIDTH-1:0] count;
        logic [CNT_WIDTH-1:0] cmp;
        logic [CNT_WIDTH-1:0] cap;
        logic [15:0]          prescale;
        logic [15:0]          div;
        logic [15:0]          cnt_shadow;
        logic [15:0]          cap_shadow;
        logic [15:0]          cnt_hold;
        logic [15:0]          cmp_hold;
        logic [31:0]          cnt_ext;
        logic [31:0]          cmp_ext;
        logic [31:0]          cap_ext;
        logic                 sel;
        logic                 wr_ctrl;
        logic                 wr_stat;
        logic                 wr_clo;
        logic                 wr_chi;
        logic                 wr_mlo;
        logic                 wr_mhi;
        logic                 wr_pre;
        logic                 rd_sel;
        logic                 rd_clo;
        logic                 rd_caplo;
        logic                 tick;
        logic                 match;
        logic                 unused_cap_shadow;

        assign sel     = wr_any && (wr_rel[5:3] == 3'(c));
        assign wr_ctrl = sel && (wr_rel[2:0] == 3'd0);
        assign wr_stat = sel && (wr_rel[2:0] == 3'd1);
        assign wr_clo  = sel && (wr_rel[2:0] == 3'd2);
        assign wr_chi  = WIDE && sel && (wr_rel[2:0] == 3'd3);
        assign wr_mlo  = sel && (wr_rel[2:0] == 3'd4);
        assign wr_mhi  = WIDE && sel && (wr_rel[2:0] == 3'd5);
        assign wr_pre  = sel && (wr_rel[2:0] == 3'd6);

        assign rd_sel   = (rd_rel < PEND_OFF) && (rd_rel[5:3] == 3'(c));
        assign rd_clo   = rd_sel && (rd_rel[2:0] == 3'd2);
        assign rd_caplo = rd_sel && (rd_rel[2:0] == 3'd7);

        // >= rather than == so a PRESCALE lowered below the running divider still ticks.
        assign tick  = en && (div >= prescale);
        assign match = (count == cmp);

        assign cnt_ext = 32'(count);
        assign cmp_ext = 32'(cmp);
        assign cap_ext = 32'(cap);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                en          <= 1'b0;
                auto_reload <= 1'b0;
                irq_en      <= 1'b0;
                flag        <= 1'b0;
                count       <= '0;
                cmp         <= '0;
                prescale    <= '0;
                div         <= '0;
                cnt_shadow  <= '0;
                cap_shadow  <= '0;
                cnt_hold    <= '0;
                cmp_hold    <= '0;
            end else begin
                if (wr_ctrl) begin
                    en          <= write_data[0];
                    auto_reload <= write_data[1];
                    irq_en      <= write_data[2];
                end

                if (wr_ctrl && !write_data[0]) begin
                    div <= '0;
                end else if (tick) begin
                    div <= '0;
                end else if (en) begin
                    div <= div + 16'd1;
                end

                // A bus commit wins over the tick's increment or reload.
                if (wr_clo) begin
                    count <= CNT_WIDTH'({cnt_hold, write_data});
                end else if (tick) begin
                    count <= (match && auto_reload) ? '0 : count + CNT_WIDTH'(1);
                end

                flag <= (flag && !(wr_stat && write_data[0])) || (tick && match);

                if (wr_mlo) cmp      <= CNT_WIDTH'({cmp_hold, write_data});
                if (wr_chi) cnt_hold <= write_data;
                if (wr_mhi) cmp_hold <= write_data;
                if (wr_pre) prescale <= write_data;

                if (rd_clo)   cnt_shadow <= cnt_ext[31:16];
                if (rd_caplo) cap_shadow <= cap_ext[31:16];
            end
        end

        // The captured high half is latched on CAP_LO reads but has no bus word of its own.
        assign unused_cap_shadow = ^cap_shadow;

`ifdef TIMER_CAPTURE_EN
        logic [2:0] cap_sync;
        logic       cap_edge;

        assign cap_edge = cap_sync[1] && !cap_sync[2];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cap_sync <= '0;
                cap      <= '0;
                cap_flag <= 1'b0;
            end else begin
                cap_sync <= {cap_sync[1:0], i_capture[c]};
                // count is the pre-commit value here, so a same-cycle bus write is not seen.
                if (cap_edge) cap <= count;
                cap_flag <= (cap_flag && !(wr_stat && write_data[1])) || cap_edge;
            end
        end
`else
        logic unused_capture;

        assign cap            = '0;
        assign cap_flag       = 1'b0;
        assign unused_capture = i_capture[c];
`endif

        assign reg_x[c][0] = {13'd0, irq_en, auto_reload, en};
        assign reg_x[c][1] = {14'd0, cap_flag, flag};
        assign reg_x[c][2] = cnt_ext[15:0];
        assign reg_x[c][3] = WIDE ? cnt_shadow : 16'd0;
        assign reg_x[c][4] = cmp_ext[15:0];
        assign reg_x[c][5] = WIDE ? cmp_ext[31:16] : 16'd0;
        assign reg_x[c][6] = prescale;
        assign reg_x[c][7] = cap_ext[15:0];

        assign flag_v[c]     = flag;
        assign cap_flag_v[c] = cap_flag;
        assign irq_en_v[c]   = irq_en;
    end

    always_comb begin
        rd_next = 16'd0;
        if (rd_rel == PEND_OFF) begin
            rd_next = 16'(flag_v);
        end else if (rd_rel < PEND_OFF) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_rel[5:3] == 3'(c)) rd_next = reg_x[c][rd_rel[2:0]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            read_data <= 16'd0;
            o_irq     <= 1'b0;
        end else begin
            read_data <= rd_next;
            o_irq     <= |((flag_v | cap_flag_v) & irq_en_v);
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: a 4-channel 32-bit instance and a 1-channel
// 16-bit instance share one bus; read data is the OR of both, as at the top level.
module tb_multi_timer;
    localparam logic [15:0] BASE   = 16'h8200;
    localparam logic [15:0] BASE16 = 16'h9000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] read_addr = 16'h0000;
    logic [15:0] write_addr = 16'h0000;
    logic [15:0] write_data = 16'h0000;
    logic        write_strobe = 1'b0;
    logic [3:0]  cap_in = 4'h0;
    logic [0:0]  cap16 = 1'b0;
    logic [15:0] rdata;
    logic [15:0] rdata16;
    logic        irq;
    logic        irq16;

    always #5 clk = ~clk;

    multi_timer #(.BASE_ADDR(BASE), .NUM_CH(4), .CNT_WIDTH(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .read_addr(read_addr), .read_data(rdata),
        .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe),
        .i_capture(cap_in), .o_irq(irq)
    );

    multi_timer #(.BASE_ADDR(BASE16), .NUM_CH(1), .CNT_WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n),
        .read_addr(read_addr), .read_data(rdata16),
        .write_addr(write_addr), .write_data(write_data), .write_strobe(write_strobe),
        .i_capture(cap16), .o_irq(irq16)
    );

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [15:0] A(int c, int off);
        return BASE + 16'(c * 8 + off);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        write_addr   = a;
        write_data   = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    // Expected value is queued when the address goes out and retired one clock later.
    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string name);
        sb_t s;
        read_addr = a;
        s.exp  = e;
        s.name = name;
        sb_q.push_back(s);
        @(negedge clk);
        s = sb_q.pop_front();
        check(s.name, rdata | rdata16, s.exp);
        read_addr = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input bit w, input logic [15:0] a, input logic [15:0] d, input string name);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.name  = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset-state reads of the whole window plus its neighbours.
        for (int off = 0; off <= 32; off++) add(1'b0, BASE + 16'(off), 16'h0000, $sformatf("reset_rd_%0d", off));
        add(1'b0, BASE - 16'd1, 16'h0000, "below_window");
        add(1'b0, BASE + 16'd33, 16'h0000, "above_window");
        // Register readback on channel 3.
        add(1'b1, A(3, 0), 16'h0006, "");
        add(1'b0, A(3, 0), 16'h0006, "ctrl_rb");
        add(1'b1, A(3, 0), 16'hFFF8, "");
        add(1'b0, A(3, 0), 16'h0000, "ctrl_mask");
        add(1'b1, A(3, 6), 16'hBEEF, "");
        add(1'b0, A(3, 6), 16'hBEEF, "prescale_rb");
        add(1'b0, A(3, 0), 16'h0000, "latency_b2b");
        add(1'b1, A(3, 5), 16'hAAAA, "");
        add(1'b0, A(3, 5), 16'h0000, "cmp_hi_held");
        add(1'b1, A(3, 4), 16'h5555, "");
        add(1'b0, A(3, 4), 16'h5555, "cmp_lo_rb");
        add(1'b0, A(3, 5), 16'hAAAA, "cmp_hi_commit");
        add(1'b1, A(3, 3), 16'h7777, "");
        add(1'b0, A(3, 3), 16'h0000, "cnt_hi_held");
        add(1'b0, A(3, 2), 16'h0000, "cnt_lo_idle");
        add(1'b1, BASE + 16'd32, 16'hFFFF, "");
        add(1'b0, BASE + 16'd32, 16'h0000, "pend_readonly");
        add(1'b1, BASE + 16'd33, 16'h1234, "");
        add(1'b0, BASE + 16'd33, 16'h0000, "outside_wr");
        add(1'b1, A(3, 7), 16'hFFFF, "");
        add(1'b0, A(3, 7), 16'h0000, "cap_not_writable");
        add(1'b1, A(3, 3), 16'h0000, "");
        add(1'b1, A(3, 5), 16'h0000, "");
        add(1'b1, A(3, 4), 16'hFFFF, "");
        add(1'b1, A(3, 6), 16'h0000, "");

        idle(2);
        check("reset_read_data", rdata | rdata16, 16'h0000);
        check("reset_irq", 16'(irq), 16'h0000);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
            else               rd(vecs[i].addr, vecs[i].data, vecs[i].name);
        end

        // Ch0: divide by 4, match at 10 with reload -> flag on the 11th tick, 44 cycles in.
        wr(A(0, 6), 16'd3);
        wr(A(0, 4), 16'd10);
        wr(A(0, 0), 16'h0003);
        idle(43);
        rd(A(0, 1), 16'h0000, "ch0_flag_before");
        rd(A(0, 1), 16'h0001, "ch0_flag_at44");
        rd(A(0, 2), 16'h0000, "ch0_reloaded");
        rd(BASE + 16'd32, 16'h0001, "irq_pend_ch0");
        check("ch0_irq_masked", 16'(irq), 16'h0000);
        wr(A(0, 0), 16'h0000);
        wr(A(0, 1), 16'h0001);
        rd(BASE + 16'd32, 16'h0000, "irq_pend_clear");

        // Ch2: match at 5 with irq_en, no reload.
        wr(A(2, 4), 16'd5);
        wr(A(2, 0), 16'h0005);
        idle(6);
        check("ch2_irq_before", 16'(irq), 16'h0000);
        idle(1);
        check("ch2_irq_after", 16'(irq), 16'h0001);
        rd(A(2, 2), 16'd7, "ch2_count_continues");
        wr(A(2, 1), 16'h0001);
        check("ch2_irq_hold", 16'(irq), 16'h0001);
        idle(1);
        check("ch2_irq_cleared", 16'(irq), 16'h0000);
        wr(A(2, 4), 16'd20);
        idle(9);
        wr(A(2, 1), 16'h0001);
        rd(A(2, 1), 16'h0001, "ch2_w1c_vs_set");
        check("ch2_irq_again", 16'(irq), 16'h0001);
        wr(A(2, 0), 16'h0000);
        wr(A(2, 1), 16'h0001);
        idle(2);
        check("ch2_irq_final", 16'(irq), 16'h0000);

        // Ch3: CMP written equal to the live count matches only at the next tick.
        wr(A(3, 6), 16'd7);
        wr(A(3, 0), 16'h0001);
        idle(9);
        wr(A(3, 4), 16'd1);
        idle(5);
        rd(A(3, 1), 16'h0000, "ch3_no_instant_match");
        rd(A(3, 1), 16'h0001, "ch3_next_tick_match");
        rd(A(3, 2), 16'd2, "ch3_count_after");
        wr(A(3, 0), 16'h0000);
        wr(A(3, 1), 16'h0001);

        // Ch1: coherent 32-bit write and read while counting every cycle.
        wr(A(1, 4), 16'hFFFF);
        wr(A(1, 0), 16'h0001);
        wr(A(1, 3), 16'h1234);
        wr(A(1, 2), 16'hFFFF);
        rd(A(1, 2), 16'hFFFF, "ch1_lo_commit");
        rd(A(1, 3), 16'h1234, "ch1_hi_snapshot");
        rd(A(1, 2), 16'h0001, "ch1_lo_live");
        rd(A(1, 3), 16'h1235, "ch1_hi_carry");
        wr(A(1, 0), 16'h0000);

        // Ch1: capture input.
        wr(A(1, 3), 16'h0000);
        wr(A(1, 2), 16'h0100);
`ifdef TIMER_CAPTURE_EN
        wr(A(1, 0), 16'h0001);
        cap_in[1] = 1'b1;
        idle(4);
        cap_in[1] = 1'b0;
        wr(A(1, 0), 16'h0000);
        rd(A(1, 7), 16'h0102, "cap_value");
        rd(A(1, 1), 16'h0002, "cap_flag");
        check("cap_irq_masked", 16'(irq), 16'h0000);
        wr(A(1, 1), 16'h0002);
        rd(A(1, 1), 16'h0000, "cap_flag_w1c");
`else
        cap_in[1] = 1'b1;
        idle(4);
        cap_in[1] = 1'b0;
        idle(2);
        rd(A(1, 7), 16'h0000, "cap_absent");
        rd(A(1, 1), 16'h0000, "cap_flag_absent");
`endif

        // 16-bit instance: wrap without flag, HI words read 0, then a real match.
        wr(BASE16 + 16'd4, 16'd3);
        wr(BASE16 + 16'd3, 16'hABCD);
        wr(BASE16 + 16'd2, 16'hFFFF);
        wr(BASE16 + 16'd0, 16'h0001);
        idle(1);
        rd(BASE16 + 16'd1, 16'h0000, "w16_wrap_no_flag");
        rd(BASE16 + 16'd2, 16'h0001, "w16_count_wrapped");
        rd(BASE16 + 16'd3, 16'h0000, "w16_cnt_hi_zero");
        rd(BASE16 + 16'd5, 16'h0000, "w16_cmp_hi_zero");
        rd(BASE16 + 16'd1, 16'h0001, "w16_match");
        wr(BASE16 + 16'd0, 16'h0000);

        // Reset in the middle of counting.
        wr(A(0, 6), 16'h0000);
        wr(A(0, 0), 16'h0001);
        read_addr = A(0, 2);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rdata", rdata | rdata16, 16'h0000);
        check("async_reset_irq", 16'(irq), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_addr = 16'h0000;
        idle(5);
        rd(A(0, 2), 16'h0000, "post_reset_ch0_count");
        rd(A(0, 0), 16'h0000, "post_reset_ch0_ctrl");
        rd(A(1, 2), 16'h0000, "post_reset_ch1_count");
        rd(BASE16 + 16'd4, 16'h0000, "post_reset_w16_cmp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
